// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
package fetch_unit_pkg;

    typedef logic [31:0] u32_t;

    typedef struct packed {
        u32_t ia_plus_4;
        u32_t ir;
    } id_params_t;

    localparam u32_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic u32_t word_align(input u32_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the memory response port and decode.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  id_params_t    data_i,
    input  logic          pop_i,
    output id_params_t    data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    id_params_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && valid_o;
    // A full buffer only accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= bump(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, redirect
// flush/drop and a decode-side buffer. FETCH_ALIGN_CHECK_EN adds fault/HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter u32_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int   DEPTH        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       redirect_valid,
    input  u32_t       redirect_addr,
    output logic       imem_req,
    output u32_t       imem_addr,
    input  logic       imem_ack,
    input  logic       imem_rvalid,
    input  u32_t       imem_rdata,
    output logic       id_valid,
    input  logic       id_ready,
    output id_params_t id_params
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic       fetch_fault
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    u32_t          pc_q, pc_d;
    u32_t          resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occ;
    logic          run_en, req_fire, rsp, rsp_take, push, pop;
    u32_t          redir_tgt;
    id_params_t    push_data;

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_state_e state_q, state_d;
    logic         fault_q, fault_d;
    logic         redir_bad;

    assign redir_bad = (redirect_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            if (redir_bad) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                fault_d = 1'b0;
            end
        end
    end

    assign run_en      = (state_q == ST_RUN);
    assign fetch_fault = fault_q;
`else
    assign run_en = 1'b1;
`endif

    assign redir_tgt = word_align(redirect_addr);

    // Credit check counts the head leaving this cycle so 1 instr/cycle
    // sustains at DEPTH=2; the pop is real, so a raised request stays raised.
    assign occ      = {1'b0, outst_q} + {1'b0, fifo_cnt} - (CW + 1)'(pop);
    assign imem_req = !rst && run_en && (occ < (CW + 1)'(DEPTH));
    assign imem_addr = pc_q;

    assign req_fire = imem_req && imem_ack;
    assign rsp      = imem_rvalid && (outst_q != '0);
    assign rsp_take = rsp && (drop_q == '0);
    assign push     = rsp_take && !redirect_valid;
    assign pop      = id_valid && id_ready;

    assign push_data.ia_plus_4 = resp_pc_q + 32'd4;
    assign push_data.ir        = imem_rdata;

    always_comb begin
        outst_d   = outst_q + CW'(req_fire) - CW'(rsp);
        pc_d      = req_fire ? pc_q + 32'd4 : pc_q;
        resp_pc_d = push ? resp_pc_q + 32'd4 : resp_pc_q;
        drop_d    = (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = redir_tgt;
            resp_pc_d = redir_tgt;
            drop_d    = outst_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_VECTOR;
            resp_pc_q <= RESET_VECTOR;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (id_params),
        .valid_o (id_valid),
        .count_o (fifo_cnt)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning max (in-flight requests + buffered instructions); legal range 2..4.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  branch/exception redirect this cycle.
REQ-006 SHALL have port redirect_addr  input  32  new fetch address.
REQ-007 SHALL have port imem_req  output  1  instruction read request.
REQ-008 SHALL have port imem_addr  output  32  request address, word-aligned.
REQ-009 SHALL have port imem_ack  input  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  read data valid, in request order.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port id_valid  output  1  id_params holds a valid instruction.
REQ-013 SHALL have port id_ready  input  1  decode stage accepts.
REQ-014 SHALL have port id_params  output  id_params_t  {ia_plus_4, ir}.
REQ-015 SHALL have port fetch_fault  output  1  misaligned redirect detected (present only with FETCH_ALIGN_CHECK_EN).

Function
REQ-016 SHALL keep PC register; imem_addr = PC while imem_req high; PC += 4 on imem_req & imem_ack, wrapping modulo 2^32.
REQ-017 SHALL assert imem_req only when outstanding + fifo_count < DEPTH; once asserted hold imem_req and imem_addr stable until imem_ack, except on redirect.
REQ-018 SHALL count outstanding: +1 on req&ack, -1 on imem_rvalid; both same cycle -> unchanged.
REQ-019 SHALL push {addr+4, imem_rdata} into a DEPTH-entry FIFO on imem_rvalid when drop_cnt == 0; ia_plus_4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-020 SHALL drive id_valid = FIFO non-empty, id_params = FIFO head; pop on id_valid & id_ready; push and pop same cycle allowed when full.
REQ-021 SHALL, on redirect_valid: flush FIFO, PC <= redirect_addr next cycle, drop_cnt <= outstanding including any ack accepted that same cycle; unacked pending request withdrawn.
REQ-022 SHALL discard imem_rvalid responses while drop_cnt > 0, decrementing drop_cnt; new requests permitted during dropping.
REQ-023 SHALL give latency: with 1-cycle memory (rvalid the cycle after ack), id_valid rises the cycle after imem_rvalid; throughput 1 instr/cycle sustained when id_ready high.
REQ-024 SHALL have states RUN and HALT; RUN -> HALT only per REQ-029; HALT -> RUN on non-faulting redirect.
REQ-025 SHALL give redirect priority over a same-cycle pop; popped entry still consumed by decode.

Reset
REQ-026 SHALL on rst: PC = RESET_VECTOR, state RUN, FIFO empty, outstanding = 0, drop_cnt = 0, imem_req = 0, id_valid = 0, fetch_fault = 0.
REQ-027 SHALL raise imem_req the first clk edge after rst deasserts; responses arriving during rst are ignored.

Configuration
REQ-028 SHALL compile alignment checking under macro FETCH_ALIGN_CHECK_EN.
REQ-029 SHALL, with FETCH_ALIGN_CHECK_EN, on redirect_addr[1:0] != 0: flush as REQ-021, enter HALT, set fetch_fault (sticky until next aligned redirect or reset), issue no requests.
REQ-030 SHALL, without FETCH_ALIGN_CHECK_EN, force redirect_addr[1:0] to 2'b00, omit fetch_fault and HALT.

Structure
REQ-031 SHALL use id_params_t and u32_t from the shared types package; add RESET_VECTOR default constant there.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth, element id_params_t, flush input).

Verification
REQ-033 Reset release, 1-cycle memory, id_ready=1 -> imem_addr 0,4,8...; id_params.ia_plus_4 4,8,12 consecutive cycles.
REQ-034 id_ready=0 for 10 cycles -> id_valid stays 1, FIFO holds 2, imem_req low after 2 acks; release -> no lost/duplicated ir.
REQ-035 Redirect to 32'h100 with 2 outstanding -> both responses dropped, next id_params.ia_plus_4 = 32'h104.
REQ-036 Redirect to 32'hFFFF_FFFC -> ia_plus_4 32'h0, next imem_addr 32'h0.
REQ-037 With FETCH_ALIGN_CHECK_EN, redirect to 32'h102 -> fetch_fault=1, imem_req=0; redirect to 32'h200 -> fault clears, fetch resumes at 32'h200.
REQ-038 rst asserted mid-stream with memory rvalid pending -> all outputs at reset values same cycle; first post-reset id_params.ir matches RESET_VECTOR word.
